namuru_tb_ctrl: RTL and testbench
=================================

Name: namuru_tb_ctrl

Overview:
Bus-side controller and interrupt scheduler for the correlator time base.
- Holds TIC and ACCUM divide values and drives them into the time base's divide inputs; new values are applied only at period boundaries, so no period is ever cut short.
- Turns the time base's pre_tic_enable/accum_enable strobes into sticky status flags, a level interrupt and a saturating missed-accumulation counter.
- Sits between the CPU register bus and the time base.

Parameters:
TIC_DIV_RST, 24'h18FFFF, tic_divide reset value (0.1 s at 16.384 MHz)
ACC_DIV_RST, 24'h001FFF, accum_divide reset value (0.5 ms)

Ports:
clk  in  1  system clock
rst  in  1  synchronous reset, active-high
wr_en  in  1  register write strobe, one cycle per write
wr_addr  in  3  write register address
wr_data  in  24  write data
rd_en  in  1  register read strobe
rd_addr  in  3  read register address
rd_data  out  24  read data, registered
pre_tic_enable  in  1  time base TIC-boundary strobe
accum_enable  in  1  time base accumulation strobe
tic_count  in  24  time base TIC counter value
tic_divide  out  24  active TIC divide value, to time base
accum_divide  out  24  active ACCUM divide value, to time base
irq  out  1  level interrupt to CPU

Behaviour:
- Clock and reset: single clock clk; rst is synchronous and active-high.
- Reset values: tic_divide=TIC_DIV_RST, accum_divide=ACC_DIV_RST; shadows equal the actives; pending bits, flags, ctrl, missed count, snapshot and rd_data all 0; irq=0.
- Writes, decoded from wr_addr when wr_en=1:
  - 0: tic shadow<=wr_data; tic_pend<=1.
  - 1: accum shadow<=wr_data; acc_pend<=1.
  - 2: ctrl<=wr_data[1:0]; bit0=acc_irq_en, bit1=tic_irq_en.
  - 3: write-1-to-clear. bit0 clears acc_flag, bit1 clears tic_flag, bit7 zeroes the missed count.
  - 4..7: ignored.
- Boundary apply, TIC:
  - On the edge where pre_tic_enable=1 and tic_pend=1: tic_divide<=shadow, tic_pend<=0.
  - The time base loads the old value on that same edge, so the new value governs the period after next reload.
- Boundary apply, ACCUM: same rule using accum_enable, acc_pend and accum_divide.
- Write coinciding with apply: the apply uses the old shadow; the write lands in the shadow and the pending bit stays 1.
- Flags:
  - pre_tic_enable=1 sets tic_flag.
  - accum_enable=1 sets acc_flag.
  - A set and a clear in the same cycle: set wins.
- Missed count: 8-bit, saturates at 255.
  - Increments when accum_enable=1 while acc_flag=1 and acc_flag is not being cleared that cycle.
  - Bit7 zeroing and an increment in the same cycle: result is 0.
- irq = (acc_flag & acc_irq_en) | (tic_flag & tic_irq_en). Built from registers only; asserts the cycle after the strobe edge.
- Reads: rd_data is updated one cycle after rd_en=1 and holds otherwise. Read has no side effects.
  - 0: active tic_divide
  - 1: active accum_divide
  - 2: {22'b0, ctrl}
  - 3: {missed[7:0] at 15:8, acc_pend at 3, tic_pend at 2, tic_flag at 1, acc_flag at 0}
  - 4: snapshot
  - 5: tic shadow
  - 6: accum shadow
  - 7: 0
- Reset mid-operation (rst=1 for one cycle): every register returns to its reset value on that edge; any pending update is discarded.

Optional Feature:
NAMURU_TB_SNAPSHOT_EN
- Defined: on every accum_enable=1 edge, snapshot<=tic_count; address 4 returns the snapshot.
- Undefined: no snapshot register is built and address 4 reads 0.

Test Plan:
- Reset: after rst, read 0 -> 24'h18FFFF, read 1 -> 24'h001FFF, read 3 -> 0, irq=0.
- Deferred TIC apply: write addr0=24'h000063; tic_divide stays 24'h18FFFF and status bit2=1 until a pre_tic_enable pulse; next cycle tic_divide=24'h000063 and bit2=0.
- Write coinciding with apply: write addr1=24'h0000FF, then addr1=24'h000010 on the same cycle as accum_enable. Expected: accum_divide=24'h0000FF, shadow=24'h000010, acc_pend=1; the next accum_enable applies 24'h000010.
- Flag, irq and clear: ctrl=1, then an accum_enable pulse -> irq=1 one cycle later. Write addr3=1 -> irq=0. Repeat with the clear coinciding with accum_enable -> flag stays 1.
- Missed count: acc_flag=1 and 300 accum_enable pulses without clear -> status[15:8]=255. Write addr3=8'h80 -> 0.
- Snapshot (macro defined): tic_count=24'h123456 when accum_enable fires -> read 4 returns 24'h123456. With the macro undefined, read 4 returns 0.

Source files
------------

// File: rtl/namuru_tb_ctrl.sv
// Register-bus controller and interrupt scheduler for the correlator time base.
// Define NAMURU_TB_SNAPSHOT_EN to build the tic_count snapshot register read at address 4.
module namuru_tb_ctrl #(
  parameter logic [23:0] TIC_DIV_RST = 24'h18FFFF,
  parameter logic [23:0] ACC_DIV_RST = 24'h001FFF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        wr_en,
  input  logic [2:0]  wr_addr,
  input  logic [23:0] wr_data,
  input  logic        rd_en,
  input  logic [2:0]  rd_addr,
  output logic [23:0] rd_data,
  input  logic        pre_tic_enable,
  input  logic        accum_enable,
  input  logic [23:0] tic_count,
  output logic [23:0] tic_divide,
  output logic [23:0] accum_divide,
  output logic        irq
);

  logic [23:0] tic_div_q, tic_div_d;
  logic [23:0] acc_div_q, acc_div_d;
  logic [23:0] tic_sh_q, tic_sh_d;
  logic [23:0] acc_sh_q, acc_sh_d;
  logic [23:0] rd_data_q, rd_data_d;
  logic        tic_pend_q, tic_pend_d;
  logic        acc_pend_q, acc_pend_d;
  logic        tic_flag_q, tic_flag_d;
  logic        acc_flag_q, acc_flag_d;
  logic [1:0]  ctrl_q, ctrl_d;
  logic [7:0]  missed_q, missed_d;

  logic wr_tic, wr_acc, wr_ctrl, wr_clr;
  logic clr_acc, clr_tic, clr_miss, miss_inc;

`ifdef NAMURU_TB_SNAPSHOT_EN
  logic [23:0] snap_q, snap_d;
`else
  logic snap_unused;
  assign snap_unused = ^tic_count;
`endif

  always_comb begin
    // NOTE: every _d starts from its hold value so no branch can leave it unassigned (no latch).
    tic_div_d  = tic_div_q;
    acc_div_d  = acc_div_q;
    tic_sh_d   = tic_sh_q;
    acc_sh_d   = acc_sh_q;
    rd_data_d  = rd_data_q;
    tic_pend_d = tic_pend_q;
    acc_pend_d = acc_pend_q;
    ctrl_d     = ctrl_q;
    missed_d   = missed_q;
`ifdef NAMURU_TB_SNAPSHOT_EN
    snap_d     = accum_enable ? tic_count : snap_q;
`endif

    wr_tic   = wr_en && (wr_addr == 3'd0);
    wr_acc   = wr_en && (wr_addr == 3'd1);
    wr_ctrl  = wr_en && (wr_addr == 3'd2);
    wr_clr   = wr_en && (wr_addr == 3'd3);
    clr_acc  = wr_clr && wr_data[0];
    clr_tic  = wr_clr && wr_data[1];
    clr_miss = wr_clr && wr_data[7];
    miss_inc = accum_enable && acc_flag_q && !clr_acc;

    // Apply takes the old shadow; a same-cycle write then re-arms the pending bit.
    if (pre_tic_enable && tic_pend_q) begin
      tic_div_d  = tic_sh_q;
      tic_pend_d = 1'b0;
    end
    if (wr_tic) begin
      tic_sh_d   = wr_data;
      tic_pend_d = 1'b1;
    end

    if (accum_enable && acc_pend_q) begin
      acc_div_d  = acc_sh_q;
      acc_pend_d = 1'b0;
    end
    if (wr_acc) begin
      acc_sh_d   = wr_data;
      acc_pend_d = 1'b1;
    end

    if (wr_ctrl) ctrl_d = wr_data[1:0];

    tic_flag_d = pre_tic_enable | (tic_flag_q & ~clr_tic);
    acc_flag_d = accum_enable | (acc_flag_q & ~clr_acc);

    if (clr_miss) begin
      missed_d = 8'd0;
    end else if (miss_inc && (missed_q != 8'hFF)) begin
      missed_d = missed_q + 8'd1;
    end

    if (rd_en) begin
      case (rd_addr)
        3'd0: rd_data_d = tic_div_q;
        3'd1: rd_data_d = acc_div_q;
        3'd2: rd_data_d = {22'd0, ctrl_q};
        3'd3: rd_data_d = {8'd0, missed_q, 4'd0, acc_pend_q, tic_pend_q, tic_flag_q, acc_flag_q};
        3'd4: begin
`ifdef NAMURU_TB_SNAPSHOT_EN
          rd_data_d = snap_q;
`else
          rd_data_d = 24'd0;
`endif
        end
        3'd5: rd_data_d = tic_sh_q;
        3'd6: rd_data_d = acc_sh_q;
        default: rd_data_d = 24'd0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignment so every flop samples pre-edge values.
    if (rst) begin
      tic_div_q  <= TIC_DIV_RST;
      acc_div_q  <= ACC_DIV_RST;
      tic_sh_q   <= TIC_DIV_RST;
      acc_sh_q   <= ACC_DIV_RST;
      rd_data_q  <= 24'd0;
      tic_pend_q <= 1'b0;
      acc_pend_q <= 1'b0;
      tic_flag_q <= 1'b0;
      acc_flag_q <= 1'b0;
      ctrl_q     <= 2'd0;
      missed_q   <= 8'd0;
`ifdef NAMURU_TB_SNAPSHOT_EN
      snap_q     <= 24'd0;
`endif
    end else begin
      tic_div_q  <= tic_div_d;
      acc_div_q  <= acc_div_d;
      tic_sh_q   <= tic_sh_d;
      acc_sh_q   <= acc_sh_d;
      rd_data_q  <= rd_data_d;
      tic_pend_q <= tic_pend_d;
      acc_pend_q <= acc_pend_d;
      tic_flag_q <= tic_flag_d;
      acc_flag_q <= acc_flag_d;
      ctrl_q     <= ctrl_d;
      missed_q   <= missed_d;
`ifdef NAMURU_TB_SNAPSHOT_EN
      snap_q     <= snap_d;
`endif
    end
  end

  assign tic_divide   = tic_div_q;
  assign accum_divide = acc_div_q;
  assign rd_data      = rd_data_q;
  assign irq          = (acc_flag_q & ctrl_q[0]) | (tic_flag_q & ctrl_q[1]);

endmodule

// File: tb/tb_namuru_tb_ctrl.sv
// Bench for namuru_tb_ctrl: directed vector table, multi-cycle corner sequences,
// then randomized traffic compared against a rule-level reference model.
module tb_namuru_tb_ctrl;

  localparam logic [23:0] T0 = 24'h18FFFF;
  localparam logic [23:0] A0 = 24'h001FFF;
`ifdef NAMURU_TB_SNAPSHOT_EN
  localparam bit          SNAP_ON  = 1'b1;
  localparam logic [23:0] SNAP_EXP = 24'h123456;
`else
  localparam bit          SNAP_ON  = 1'b0;
  localparam logic [23:0] SNAP_EXP = 24'h000000;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        wr_en = 1'b0;
  logic [2:0]  wr_addr = '0;
  logic [23:0] wr_data = '0;
  logic        rd_en = 1'b0;
  logic [2:0]  rd_addr = '0;
  logic [23:0] rd_data;
  logic        pre_tic_enable = 1'b0;
  logic        accum_enable = 1'b0;
  logic [23:0] tic_count = '0;
  logic [23:0] tic_divide;
  logic [23:0] accum_divide;
  logic        irq;

  int total = 0;
  int bad   = 0;

  namuru_tb_ctrl dut (
    .clk(clk), .rst(rst),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data),
    .pre_tic_enable(pre_tic_enable), .accum_enable(accum_enable), .tic_count(tic_count),
    .tic_divide(tic_divide), .accum_divide(accum_divide), .irq(irq)
  );

  always #5 clk = ~clk;

  // Reference model: register contents tracked as plain values, updated by the rules per edge.
  typedef struct {
    logic [23:0] tic_div, acc_div, tic_sh, acc_sh, snap, rd;
    bit          tic_pend, acc_pend, tic_flag, acc_flag;
    logic [1:0]  ctrl;
    int          missed;
  } model_t;
  model_t m;

  function automatic logic [23:0] model_read(model_t s, logic [2:0] a);
    case (a)
      3'd0: return s.tic_div;
      3'd1: return s.acc_div;
      3'd2: return 24'(s.ctrl);
      3'd3: return 24'(s.missed * 256 + int'(s.acc_pend) * 8 + int'(s.tic_pend) * 4
                       + int'(s.tic_flag) * 2 + int'(s.acc_flag));
      3'd4: return SNAP_ON ? s.snap : 24'd0;
      3'd5: return s.tic_sh;
      3'd6: return s.acc_sh;
      default: return 24'd0;
    endcase
  endfunction

  task automatic model_reset();
    m.tic_div = T0; m.acc_div = A0; m.tic_sh = T0; m.acc_sh = A0;
    m.snap = '0; m.rd = '0; m.ctrl = '0; m.missed = 0;
    m.tic_pend = 0; m.acc_pend = 0; m.tic_flag = 0; m.acc_flag = 0;
  endtask

  task automatic model_edge();
    model_t o;
    bit clr;
    o = m;
    if (rst) begin
      model_reset();
    end else begin
      clr = wr_en && wr_addr == 3'd3;
      if (rd_en) m.rd = model_read(o, rd_addr);
      if (pre_tic_enable && o.tic_pend) begin m.tic_div = o.tic_sh; m.tic_pend = 0; end
      if (accum_enable && o.acc_pend) begin m.acc_div = o.acc_sh; m.acc_pend = 0; end
      if (wr_en && wr_addr == 3'd0) begin m.tic_sh = wr_data; m.tic_pend = 1; end
      if (wr_en && wr_addr == 3'd1) begin m.acc_sh = wr_data; m.acc_pend = 1; end
      if (wr_en && wr_addr == 3'd2) m.ctrl = wr_data[1:0];
      if (clr && wr_data[1]) m.tic_flag = 0;
      if (clr && wr_data[0]) m.acc_flag = 0;
      if (pre_tic_enable) m.tic_flag = 1;
      if (accum_enable) m.acc_flag = 1;
      if (accum_enable && o.acc_flag && !(clr && wr_data[0]))
        m.missed = (o.missed < 255) ? o.missed + 1 : 255;
      if (clr && wr_data[7]) m.missed = 0;
      if (accum_enable) m.snap = tic_count;
    end
  endtask

  function automatic logic model_irq();
    return (m.acc_flag && m.ctrl[0]) || (m.tic_flag && m.ctrl[1]);
  endfunction

  task automatic check(string name, logic [23:0] act, logic [23:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(logic we, logic [2:0] wa, logic [23:0] wd, logic re, logic [2:0] ra,
                       logic p, logic a, logic [23:0] tc);
    wr_en = we; wr_addr = wa; wr_data = wd; rd_en = re; rd_addr = ra;
    pre_tic_enable = p; accum_enable = a; tic_count = tc;
  endtask

  // Model sees the same inputs the DUT samples on the coming edge; outputs checked 1 ns after.
  task automatic step();
    model_edge();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic        we;
    logic [2:0]  wa;
    logic [23:0] wd;
    logic        re;
    logic [2:0]  ra;
    logic        p, a;
    logic [23:0] tc;
    logic [23:0] e_tic, e_acc, e_rd;
    logic        e_irq;
  } vec_t;

  function automatic vec_t mk(logic we, logic [2:0] wa, logic [23:0] wd, logic re, logic [2:0] ra,
                              logic p, logic a, logic [23:0] tc,
                              logic [23:0] et, logic [23:0] ea, logic [23:0] er, logic ei);
    vec_t v;
    v.we = we; v.wa = wa; v.wd = wd; v.re = re; v.ra = ra; v.p = p; v.a = a; v.tc = tc;
    v.e_tic = et; v.e_acc = ea; v.e_rd = er; v.e_irq = ei;
    return v;
  endfunction

  vec_t tbl [29];

  initial begin
    tbl[0]  = mk(0, 0, 0,         1, 0, 0, 0, 0,         T0,    A0,    T0,       0);
    tbl[1]  = mk(0, 0, 0,         1, 1, 0, 0, 0,         T0,    A0,    A0,       0);
    tbl[2]  = mk(0, 0, 0,         1, 3, 0, 0, 0,         T0,    A0,    24'h0,    0);
    tbl[3]  = mk(1, 0, 24'h63,    1, 3, 0, 0, 0,         T0,    A0,    24'h0,    0);
    tbl[4]  = mk(0, 0, 0,         1, 3, 0, 0, 0,         T0,    A0,    24'h4,    0);
    tbl[5]  = mk(0, 0, 0,         1, 5, 0, 0, 0,         T0,    A0,    24'h63,   0);
    tbl[6]  = mk(0, 0, 0,         0, 0, 1, 0, 0,         24'h63, A0,   24'h63,   0);
    tbl[7]  = mk(0, 0, 0,         1, 3, 0, 0, 0,         24'h63, A0,   24'h2,    0);
    tbl[8]  = mk(1, 3, 24'h2,     0, 0, 0, 0, 0,         24'h63, A0,   24'h2,    0);
    tbl[9]  = mk(1, 1, 24'hFF,    0, 0, 0, 0, 0,         24'h63, A0,   24'h2,    0);
    tbl[10] = mk(1, 1, 24'h10,    0, 0, 0, 1, 0,         24'h63, 24'hFF, 24'h2,  0);
    tbl[11] = mk(0, 0, 0,         1, 3, 0, 0, 0,         24'h63, 24'hFF, 24'h9,  0);
    tbl[12] = mk(0, 0, 0,         1, 6, 0, 0, 0,         24'h63, 24'hFF, 24'h10, 0);
    tbl[13] = mk(0, 0, 0,         0, 0, 0, 1, 0,         24'h63, 24'h10, 24'h10, 0);
    tbl[14] = mk(0, 0, 0,         1, 3, 0, 0, 0,         24'h63, 24'h10, 24'h101, 0);
    tbl[15] = mk(1, 3, 24'h81,    0, 0, 0, 0, 0,         24'h63, 24'h10, 24'h101, 0);
    tbl[16] = mk(1, 2, 24'h1,     0, 0, 0, 0, 0,         24'h63, 24'h10, 24'h101, 0);
    tbl[17] = mk(0, 0, 0,         0, 0, 0, 1, 0,         24'h63, 24'h10, 24'h101, 1);
    tbl[18] = mk(1, 3, 24'h1,     0, 0, 0, 0, 0,         24'h63, 24'h10, 24'h101, 0);
    tbl[19] = mk(1, 3, 24'h1,     0, 0, 0, 1, 24'h123456, 24'h63, 24'h10, 24'h101, 1);
    tbl[20] = mk(0, 0, 0,         1, 3, 0, 0, 0,         24'h63, 24'h10, 24'h1,  1);
    tbl[21] = mk(1, 2, 24'h3,     0, 0, 1, 0, 0,         24'h63, 24'h10, 24'h1,  1);
    tbl[22] = mk(1, 3, 24'h1,     0, 0, 0, 0, 0,         24'h63, 24'h10, 24'h1,  1);
    tbl[23] = mk(1, 3, 24'h2,     0, 0, 0, 0, 0,         24'h63, 24'h10, 24'h1,  0);
    tbl[24] = mk(0, 0, 0,         1, 4, 0, 0, 0,         24'h63, 24'h10, SNAP_EXP, 0);
    tbl[25] = mk(0, 0, 0,         1, 2, 0, 0, 0,         24'h63, 24'h10, 24'h3,  0);
    tbl[26] = mk(0, 0, 0,         1, 7, 0, 0, 0,         24'h63, 24'h10, 24'h0,  0);
    tbl[27] = mk(1, 5, 24'hABCDEF, 1, 5, 0, 0, 0,        24'h63, 24'h10, 24'h63, 0);
    tbl[28] = mk(0, 0, 0,         1, 5, 0, 0, 0,         24'h63, 24'h10, 24'h63, 0);

    // Reset
    model_reset();
    rst = 1'b1;
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    step();
    step();
    rst = 1'b0;
    check("reset_tic", tic_divide, T0);
    check("reset_acc", accum_divide, A0);
    check("reset_rd", rd_data, 24'h0);
    check("reset_irq", {23'd0, irq}, 24'h0);

    // Directed vector table
    for (int i = 0; i < 29; i++) begin
      drive(tbl[i].we, tbl[i].wa, tbl[i].wd, tbl[i].re, tbl[i].ra, tbl[i].p, tbl[i].a, tbl[i].tc);
      step();
      check($sformatf("row%0d_tic", i), tic_divide, tbl[i].e_tic);
      check($sformatf("row%0d_acc", i), accum_divide, tbl[i].e_acc);
      check($sformatf("row%0d_rd", i), rd_data, tbl[i].e_rd);
      check($sformatf("row%0d_irq", i), {23'd0, irq}, {23'd0, tbl[i].e_irq});
    end

    // Missed counter saturation: flag set, then 300 more accumulations without a clear
    drive(0, 0, 0, 0, 0, 0, 1, 0);
    step();
    for (int i = 0; i < 300; i++) begin
      drive(0, 0, 0, 0, 0, 0, 1, 0);
      step();
    end
    drive(0, 0, 0, 1, 3, 0, 0, 0);
    step();
    check("miss_sat", rd_data, 24'h00FF01);
    check("miss_sat_irq", {23'd0, irq}, 24'h1);
    // Zeroing coincides with an increment: zero wins, flag stays set
    drive(1, 3, 24'h80, 0, 0, 0, 1, 0);
    step();
    drive(0, 0, 0, 1, 3, 0, 0, 0);
    step();
    check("miss_zero", rd_data, 24'h000001);

    // Reset mid-operation discards pending updates
    drive(1, 0, 24'h000777, 0, 0, 0, 0, 0);
    step();
    drive(1, 1, 24'h000555, 0, 0, 0, 0, 0);
    step();
    rst = 1'b1;
    drive(0, 0, 0, 1, 0, 1, 1, 0);
    step();
    rst = 1'b0;
    check("midrst_tic", tic_divide, T0);
    check("midrst_acc", accum_divide, A0);
    check("midrst_rd", rd_data, 24'h0);
    check("midrst_irq", {23'd0, irq}, 24'h0);
    drive(0, 0, 0, 0, 0, 1, 1, 0);
    step();
    check("midrst_tic_after", tic_divide, T0);
    check("midrst_acc_after", accum_divide, A0);
    drive(0, 0, 0, 1, 5, 0, 0, 0);
    step();
    check("midrst_shadow", rd_data, T0);
    drive(0, 0, 0, 1, 3, 0, 0, 0);
    step();
    check("midrst_status", rd_data, 24'h000003);

    // Randomized traffic against the reference model
    for (int i = 0; i < 3000; i++) begin
      rst = ($urandom_range(0, 499) == 0);
      drive(($urandom_range(0, 2) == 0), 3'($urandom_range(0, 7)), 24'($urandom),
            $urandom_range(0, 1) == 1, 3'($urandom_range(0, 7)),
            ($urandom_range(0, 7) == 0), ($urandom_range(0, 3) == 0), 24'($urandom));
      step();
      check("rand_tic", tic_divide, m.tic_div);
      check("rand_acc", accum_divide, m.acc_div);
      check("rand_rd", rd_data, m.rd);
      check("rand_irq", {23'd0, irq}, {23'd0, model_irq()});
    end
    rst = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
